// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//   Register file with a pending-write scoreboard for an in-order RV32I pipeline.
//   The file has NUM_RD combinational read ports and one synchronous write port.
//   Index 0 can be hardwired to zero. A write can be forwarded to a read in the
//   same cycle. Each register has one pending bit: decode sets it when it issues
//   a producer, and writeback clears it when that producer retires.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   read_addr     NUM_RD packed read indices, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   data_out      NUM_RD packed read data, same packing as read_addr
//   rd_busy       per read port: the register it reads still has a write outstanding
//   regWrite      writeback write enable
//   write_addr    writeback destination index
//   data_in       writeback data
//   issue         decode issued a producer targeting issue_addr
//   issue_addr    destination index of the issued producer
//   flush         clear every pending bit at the next edge
//   pend_cnt      number of registers currently marked pending
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module reg_file_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int WORD_WIDTH = `WORD_WIDTH,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   read_addr,
    output logic [NUM_RD*WORD_WIDTH-1:0]   data_out,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic                           regWrite,
    input  logic [ADDR_WIDTH-1:0]          write_addr,
    input  logic [WORD_WIDTH-1:0]          data_in,
    input  logic                           issue,
    input  logic [ADDR_WIDTH-1:0]          issue_addr,
    input  logic                           flush,
    output logic [ADDR_WIDTH:0]            pend_cnt
);

    localparam int REGS = 1 << ADDR_WIDTH;

    logic [WORD_WIDTH-1:0] regs_q [REGS];
    logic [WORD_WIDTH-1:0] regs_d [REGS];
    logic [REGS-1:0]       pending_q;
    logic [REGS-1:0]       pending_d;
    logic                  wr_en;
    logic                  iss_en;
    logic [ADDR_WIDTH:0]   cnt;

    // Writes and issues to x0 are dropped when x0 is hardwired.
    assign wr_en  = regWrite && !((ZERO_REG != 0) && (write_addr == '0));
    assign iss_en = issue    && !((ZERO_REG != 0) && (issue_addr == '0));

    // The order of the updates below sets their priority. A retiring write clears
    // its pending bit. A same-edge issue to that register sets the bit again,
    // because the newer producer is still in flight. Flush clears every bit last,
    // so it overrides both, but the register data is still written.
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        if (wr_en) begin
            regs_d[write_addr]    = data_in;
            pending_d[write_addr] = 1'b0;
        end
        if (iss_en) begin
            pending_d[issue_addr] = 1'b1;
        end
        if (flush) begin
            pending_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
        end
    end

    // Read ports. While rst is high every port returns zero and is not busy,
    // whatever the other inputs are. That includes a write that would otherwise
    // be forwarded. A forwarded read returns the retiring data and is not busy,
    // because that write is the one the reader was waiting for.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] idx;
        logic                  is_zero;
        logic                  hit;

        assign idx     = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign is_zero = (ZERO_REG != 0) && (idx == '0);
        assign hit     = (BYPASS != 0) && wr_en && (idx == write_addr);

        assign data_out[p*WORD_WIDTH +: WORD_WIDTH] =
            (rst || is_zero) ? '0 : (hit ? data_in : regs_q[idx]);
        assign rd_busy[p] = !(rst || is_zero || hit) && pending_q[idx];
    end

    // pend_cnt counts only stored pending bits, so a forwarded write does not
    // lower it until the edge where that write retires.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < REGS; i++) begin
            cnt = cnt + {{ADDR_WIDTH{1'b0}}, pending_q[i]};
        end
    end

    assign pend_cnt = cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
`timescale 1ns/1ps

module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  read_addr;
    logic [63:0] dout_b, dout_n;
    logic [1:0]  busy_b, busy_n;
    logic        regWrite;
    logic [4:0]  write_addr;
    logic [31:0] data_in;
    logic        issue;
    logic [4:0]  issue_addr;
    logic        flush;
    logic [5:0]  cnt_b, cnt_n;

    always #5 clk = ~clk;

    reg_file_sb #(.ADDR_WIDTH(5), .WORD_WIDTH(32), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst(rst), .read_addr(read_addr), .data_out(dout_b), .rd_busy(busy_b),
        .regWrite(regWrite), .write_addr(write_addr), .data_in(data_in),
        .issue(issue), .issue_addr(issue_addr), .flush(flush), .pend_cnt(cnt_b));

    reg_file_sb #(.ADDR_WIDTH(5), .WORD_WIDTH(32), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_n (
        .clk(clk), .rst(rst), .read_addr(read_addr), .data_out(dout_n), .rd_busy(busy_n),
        .regWrite(regWrite), .write_addr(write_addr), .data_in(data_in),
        .issue(issue), .issue_addr(issue_addr), .flush(flush), .pend_cnt(cnt_n));

    // Expected outputs for one cycle. d0, d1, busy and cnt refer to the bypassing
    // instance. nd1 and nbusy1 refer to port 1 of the non-bypassing instance.
    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic [5:0]  cnt;
        logic [31:0] nd1;
        logic        nbusy1;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iss;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        exp_t        e;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state for the random phase.
    logic [31:0] m_mem  [32];
    logic        m_pend [32];

    function automatic vec_t mk(logic wr, logic [4:0] wa, logic [31:0] wd,
                                logic iss, logic [4:0] ia, logic fl,
                                logic [4:0] ra0, logic [4:0] ra1,
                                logic [31:0] d0, logic [31:0] d1, logic [1:0] busy,
                                logic [5:0] cnt, logic [31:0] nd1, logic nbusy1);
        vec_t v;
        v.wr = wr; v.wa = wa; v.wd = wd; v.iss = iss; v.ia = ia; v.fl = fl;
        v.ra0 = ra0; v.ra1 = ra1;
        v.e.d0 = d0; v.e.d1 = d1; v.e.busy = busy; v.e.cnt = cnt;
        v.e.nd1 = nd1; v.e.nbusy1 = nbusy1;
        return v;
    endfunction

    function automatic exp_t zeros();
        exp_t e;
        e.d0 = '0; e.d1 = '0; e.busy = '0; e.cnt = '0; e.nd1 = '0; e.nbusy1 = 1'b0;
        return e;
    endfunction

    task automatic cmp(input string tag, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s/scoreboard: got empty queue expected entry", tag);
            return;
        end
        e = sb_q.pop_front();
        cmp(tag, "d0",     dout_b[31:0],  e.d0);
        cmp(tag, "d1",     dout_b[63:32], e.d1);
        cmp(tag, "busy",   {30'd0, busy_b}, {30'd0, e.busy});
        cmp(tag, "cnt",    {26'd0, cnt_b},  {26'd0, e.cnt});
        cmp(tag, "nb_d1",  dout_n[63:32], e.nd1);
        cmp(tag, "nb_bsy", {31'd0, busy_n[1]}, {31'd0, e.nbusy1});
        cmp(tag, "nb_cnt", {26'd0, cnt_n},  {26'd0, e.cnt});
    endtask

    // This task is called at posedge+1. It applies one cycle of inputs, checks the
    // combinational outputs at the falling edge, and returns just after the next
    // rising edge.
    task automatic drive(input vec_t v, input string tag);
        regWrite   = v.wr;
        write_addr = v.wa;
        data_in    = v.wd;
        issue      = v.iss;
        issue_addr = v.ia;
        flush      = v.fl;
        read_addr  = {v.ra1, v.ra0};
        sb_q.push_back(v.e);
        @(negedge clk);
        check(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs(input logic [4:0] ra0, input logic [4:0] ra1);
        regWrite = 1'b0; write_addr = '0; data_in = '0;
        issue = 1'b0; issue_addr = '0; flush = 1'b0;
        read_addr = {ra1, ra0};
    endtask

    // Raise rst between clock edges. The outputs must clear at once, before
    // any clock edge.
    task automatic async_reset(input logic [4:0] ra0, input logic [4:0] ra1, input string tag);
        idle_inputs(ra0, ra1);
        rst = 1'b1;
        #2;
        sb_q.push_back(zeros());
        check(tag);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    vec_t v;
    exp_t e;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Start in reset with a live write, issue and flush on the inputs. All of
        // them must be ignored, and the forwarding path must be off.
        rst = 1'b1;
        regWrite = 1'b1; write_addr = 5'd7; data_in = 32'hFFFF_0000;
        issue = 1'b1; issue_addr = 5'd3; flush = 1'b0;
        read_addr = {5'd7, 5'd7};
        sb_q.push_back(zeros());
        @(negedge clk);
        check("reset_hold");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs(5'd0, 5'd0);
        @(posedge clk);
        #1;

        //            wr  wa     wd             iss ia    fl  ra0    ra1     d0            d1            busy   cnt   nd1           nb
        tbl.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0,  0, 5'd7,  5'd3,   32'h0,        32'h0,        2'b00, 6'd0, 32'h0,        0));
        tbl.push_back(mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0,  0, 5'd0,  5'd5,   32'h0,        32'hDEADBEEF, 2'b00, 6'd0, 32'h0,        0));
        tbl.push_back(mk(0, 5'd0, 32'h0,        1, 5'd6,  0, 5'd5,  5'd5,   32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 6'd0, 32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0,  0, 5'd5,  5'd6,   32'hDEADBEEF, 32'h0,        2'b10, 6'd1, 32'h0,        1));
        // an asynchronous reset pulse is inserted here
        tbl.push_back(mk(0, 5'd0, 32'h0,        1, 5'd9,  0, 5'd5,  5'd6,   32'h0,        32'h0,        2'b00, 6'd0, 32'h0,        0));
        tbl.push_back(mk(1, 5'd0, 32'h1234,     1, 5'd0,  0, 5'd0,  5'd0,   32'h0,        32'h0,        2'b00, 6'd1, 32'h0,        0));
        tbl.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0,  0, 5'd0,  5'd0,   32'h0,        32'h0,        2'b00, 6'd1, 32'h0,        0));
        tbl.push_back(mk(1, 5'd7, 32'hA5A5A5A5, 0, 5'd0,  0, 5'd0,  5'd7,   32'h0,        32'hA5A5A5A5, 2'b00, 6'd1, 32'h0,        0));
        tbl.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0,  0, 5'd0,  5'd7,   32'h0,        32'hA5A5A5A5, 2'b00, 6'd1, 32'hA5A5A5A5, 0));
        tbl.push_back(mk(0, 5'd0, 32'h0,        1, 5'd3,  0, 5'd0,  5'd3,   32'h0,        32'h0,        2'b00, 6'd1, 32'h0,        0));
        tbl.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0,  0, 5'd0,  5'd3,   32'h0,        32'h0,        2'b10, 6'd2, 32'h0,        1));
        tbl.push_back(mk(1, 5'd3, 32'd9,        0, 5'd0,  0, 5'd0,  5'd3,   32'h0,        32'd9,        2'b00, 6'd2, 32'h0,        1));
        tbl.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0,  0, 5'd0,  5'd3,   32'h0,        32'd9,        2'b00, 6'd1, 32'd9,        0));
        tbl.push_back(mk(1, 5'd4, 32'h11,       1, 5'd4,  0, 5'd4,  5'd4,   32'h11,       32'h11,       2'b00, 6'd1, 32'h0,        0));
        tbl.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0,  0, 5'd4,  5'd4,   32'h11,       32'h11,       2'b11, 6'd2, 32'h11,       1));
        tbl.push_back(mk(1, 5'd8, 32'h77,       0, 5'd0,  1, 5'd4,  5'd9,   32'h11,       32'h0,        2'b11, 6'd2, 32'h0,        1));
        tbl.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0,  0, 5'd8,  5'd4,   32'h77,       32'h11,       2'b00, 6'd0, 32'h11,       0));
        tbl.push_back(mk(0, 5'd0, 32'h0,        1, 5'd10, 1, 5'd10, 5'd0,   32'h0,        32'h0,        2'b00, 6'd0, 32'h0,        0));
        tbl.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0,  0, 5'd10, 5'd5,   32'h0,        32'h0,        2'b00, 6'd0, 32'h0,        0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i], $sformatf("vec%0d", i));
            if (i == 3) async_reset(5'd5, 5'd6, "mid_reset");
        end

        // Issue x1..x31 on consecutive edges, then flush together with a
        // competing issue.
        for (int i = 1; i < 32; i++) begin
            v = mk(0, 5'd0, 32'h0, 1, 5'(i), 0, 5'd0, 5'd0,
                   32'h0, 32'h0, 2'b00, 6'(i - 1), 32'h0, 0);
            drive(v, $sformatf("fill%0d", i));
        end
        drive(mk(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd31, 5'd1, 32'h0, 32'h0, 2'b11, 6'd31, 32'h0, 1), "full");
        drive(mk(0, 5'd0, 32'h0, 1, 5'd2, 1, 5'd2,  5'd0, 32'h0, 32'h0, 2'b01, 6'd31, 32'h0, 0), "flush_iss");
        drive(mk(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd2,  5'd2, 32'h0, 32'h0, 2'b00, 6'd0,  32'h0, 0), "flushed");

        // Random traffic checked against a behavioural model.
        async_reset(5'd3, 5'd4, "rand_reset");
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        for (int n = 0; n < 300; n++) begin
            int pc;
            v.wr  = ($urandom_range(0, 1) == 1);
            v.wa  = 5'($urandom_range(0, (n % 5 == 0) ? 31 : 7));
            v.wd  = $urandom;
            v.iss = ($urandom_range(0, 2) == 0);
            v.ia  = 5'($urandom_range(0, (n % 7 == 0) ? 31 : 7));
            v.fl  = ($urandom_range(0, 15) == 0);
            v.ra0 = 5'($urandom_range(0, 7));
            v.ra1 = 5'($urandom_range(0, 7));

            pc = 0;
            for (int r = 0; r < 32; r++) pc += int'(m_pend[r]);
            e.cnt = 6'(pc);
            // Port 0, bypassing instance
            if (v.ra0 == 5'd0) begin
                e.d0 = '0; e.busy[0] = 1'b0;
            end else if (v.wr && v.wa == v.ra0) begin
                e.d0 = v.wd; e.busy[0] = 1'b0;
            end else begin
                e.d0 = m_mem[v.ra0]; e.busy[0] = m_pend[v.ra0];
            end
            // Port 1, bypassing instance
            if (v.ra1 == 5'd0) begin
                e.d1 = '0; e.busy[1] = 1'b0;
            end else if (v.wr && v.wa == v.ra1) begin
                e.d1 = v.wd; e.busy[1] = 1'b0;
            end else begin
                e.d1 = m_mem[v.ra1]; e.busy[1] = m_pend[v.ra1];
            end
            // Port 1, non-bypassing instance: stored state only
            e.nd1    = (v.ra1 == 5'd0) ? 32'h0 : m_mem[v.ra1];
            e.nbusy1 = (v.ra1 == 5'd0) ? 1'b0 : m_pend[v.ra1];
            v.e = e;

            drive(v, $sformatf("rnd%0d", n));

            if (v.wr && v.wa != 5'd0) begin
                m_mem[v.wa]  = v.wd;
                m_pend[v.wa] = 1'b0;
            end
            if (v.iss && v.ia != 5'd0) m_pend[v.ia] = 1'b1;
            if (v.fl) begin
                for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
